// File: rtl/utopia_rx_cell_receiver.sv
// Utopia Level 1 Rx port receiver: requests octets from the PHY and checks the HEC of each 53-byte cell.
// Cells that are accepted are forwarded from a single-cell buffer as a valid/ready byte stream.
module utopia_rx_cell_receiver #(
  parameter logic [7:0] HEC_COSET    = 8'h55,
  parameter bit         DROP_BAD_HEC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Rx_data,
  input  logic       Rx_soc,
  input  logic       Rx_clav,
  output logic       Rx_en,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] hec_err_cnt,
  output logic [7:0] runt_cnt
);

  localparam logic [5:0] LAST_IDX  = 6'd52;
  localparam logic [5:0] CELL_LEN  = 6'd53;
  localparam logic [5:0] HEC_IDX   = 6'd4;

  typedef enum logic [1:0] {
    S_HUNT,
    S_RECV,
    S_SEND
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_rx_en;
  logic [5:0] r_cnt;
  logic [7:0] r_crc;
  logic       r_bad;
  logic [5:0] r_idx;
  logic [7:0] r_buf [0:52];

  logic [7:0] r_out_data;
  logic       r_out_sop;
  logic       r_out_eop;
  logic       r_out_err;
  logic       r_out_valid;
  logic [7:0] r_hec_err_cnt;
  logic [7:0] r_runt_cnt;

  logic       w_sample;
  logic       w_store;
  logic       w_restart;
  logic       w_runt;
  logic       w_last;
  logic       w_drop;
  logic       w_load_send;
  logic       w_xfer;
  logic       w_send_done;
  logic [5:0] w_wr_idx;
  logic [5:0] w_req;
  logic [5:0] w_idx_inc;
  logic       w_rx_en_nxt;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first
  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HUNT: if (w_sample && Rx_soc) w_state_nxt = S_RECV;
      S_RECV: if (w_last) w_state_nxt = w_drop ? S_HUNT : S_SEND;
      S_SEND: if (w_send_done) w_state_nxt = S_HUNT;
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_sample    = ~r_rx_en;
    w_store     = w_sample && ((r_state == S_RECV) || ((r_state == S_HUNT) && Rx_soc));
    w_restart   = w_store && Rx_soc;
    w_runt      = w_sample && Rx_soc && (r_state == S_RECV) && (r_cnt != 6'd0);
    w_last      = w_store && !Rx_soc && (r_state == S_RECV) && (r_cnt == LAST_IDX);
    w_drop      = r_bad && DROP_BAD_HEC;
    w_load_send = w_last && !w_drop;
    w_xfer      = r_out_valid && out_ready;
    w_send_done = (r_state == S_SEND) && w_xfer && (r_idx == LAST_IDX);
    w_wr_idx    = w_restart ? 6'd0 : r_cnt;
    w_idx_inc   = r_idx + 6'd1;
    // Requests already made this cell, including the one being sampled now;
    // Rx_en is registered, so the 53rd request must release it immediately.
    w_req       = w_store ? (w_wr_idx + 6'd1) : r_cnt;
    w_rx_en_nxt = ~(Rx_clav && ((r_state == S_HUNT) ||
                                ((r_state == S_RECV) && (w_req < CELL_LEN))));
  end

  // Cell buffer carries no reset; only bytes written this cell are ever read.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_buf[w_wr_idx] <= Rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_en       <= 1'b1;
      r_cnt         <= '0;
      r_crc         <= '0;
      r_bad         <= 1'b0;
      r_hec_err_cnt <= '0;
      r_runt_cnt    <= '0;
    end else begin
      r_rx_en <= w_rx_en_nxt;

      if (w_last) begin
        r_cnt <= '0;
      end else if (w_store) begin
        r_cnt <= w_wr_idx + 6'd1;
      end

      if (w_restart) begin
        r_crc <= f_crc8('0, Rx_data);
        r_bad <= 1'b0;
      end else if (w_store && (r_cnt < HEC_IDX)) begin
        r_crc <= f_crc8(r_crc, Rx_data);
      end else if (w_store && (r_cnt == HEC_IDX)) begin
        r_bad <= (Rx_data != (r_crc ^ HEC_COSET));
      end

      if (w_runt && (r_runt_cnt != '1)) begin
        r_runt_cnt <= r_runt_cnt + 8'd1;
      end
      if (w_last && r_bad && (r_hec_err_cnt != '1)) begin
        r_hec_err_cnt <= r_hec_err_cnt + 8'd1;
      end
    end
  end

  // Byte 0 is preloaded on the edge that stores byte 52 so out_valid rises one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_err   <= 1'b0;
      r_idx       <= '0;
    end else if (w_load_send) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_buf[0];
      r_out_sop   <= 1'b1;
      r_out_eop   <= 1'b0;
      r_out_err   <= 1'b0;
      r_idx       <= '0;
    end else if ((r_state == S_SEND) && w_xfer) begin
      if (r_idx == LAST_IDX) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_sop   <= 1'b0;
        r_out_eop   <= 1'b0;
        r_out_err   <= 1'b0;
        r_idx       <= '0;
      end else begin
        r_idx      <= w_idx_inc;
        r_out_data <= r_buf[w_idx_inc];
        r_out_sop  <= 1'b0;
        r_out_eop  <= (w_idx_inc == LAST_IDX);
        r_out_err  <= (w_idx_inc == LAST_IDX) && r_bad;
      end
    end
  end

  assign Rx_en       = r_rx_en;
  assign out_data    = r_out_data;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_err     = r_out_err;
  assign out_valid   = r_out_valid;
  assign hec_err_cnt = r_hec_err_cnt;
  assign runt_cnt    = r_runt_cnt;

endmodule

// File: doc/utopia_rx_cell_receiver.md
# utopia_rx_cell_receiver

ATM-layer side receiver for one Utopia Level 1 Rx port, placed directly upstream of the 4-port ATM router core; one instance per Rx port. Requests octets from the PHY with an Rx_clav/Rx_en handshake and aligns on Rx_soc. Checks the 53-byte cell's HEC, then forwards good cells to the router as a byte stream with valid/ready flow control. Single-cell buffer; the PHY is not serviced while a cell is being drained.

## Interface
- HEC_COSET, 8'h55, value XORed into the computed CRC-8 before comparing with byte 4
- DROP_BAD_HEC, 1, 1: discard HEC-failed cells; 0: forward them with out_err=1 on the last byte
- clk  input  1  single clock; the Utopia Rx_clk of this port is driven from clk
- rst  input  1  asynchronous, active-low reset
- Rx_data  input  8  cell octet from the PHY
- Rx_soc  input  1  start of cell, valid with Rx_data
- Rx_clav  input  1  PHY has an octet available
- Rx_en  output  1  active-low octet request (registered)
- out_data  output  8  cell byte to the router
- out_sop / out_eop  output  1  first (byte 0) / last (byte 52) byte flags
- out_err  output  1  HEC error, valid only with out_eop
- out_valid  output  1  out_data is valid
- out_ready  input  1  router accepts the byte
- hec_err_cnt  output  8  saturating count of HEC failures
- runt_cnt  output  8  saturating count of cells aborted by an early Rx_soc

## Operation
- Reset values: Rx_en=1, out_valid=0, out_data=0, out_sop=0, out_eop=0, out_err=0, both counters 0, state HUNT, byte count 0.
- Octet transfer: an octet is sampled on the rising clk edge that ends any cycle in which the registered Rx_en=0. The next-state value of Rx_en is 0 when Rx_clav=1 and (state HUNT, or state RECV with fewer than 53 octets requested); otherwise it is 1.
- HUNT: sampled octets with Rx_soc=0 are discarded. An octet with Rx_soc=1 is stored as byte 0, byte count becomes 1, and the state moves to RECV.
- RECV: each sampled octet is stored at the current byte count, and the count increments.
  - A sample with Rx_soc=1 at count≠0 increments runt_cnt, restarts the cell with this octet as byte 0, clears the CRC and continues in RECV.
  - The CRC-8 (x^8+x^2+x+1, init 0, MSB first) is updated over bytes 0-3.
  - At byte 4, bad = (byte4 ≠ crc^HEC_COSET).
  - When byte 52 is stored: if bad and DROP_BAD_HEC=1, increment hec_err_cnt and return to HUNT. Otherwise, if bad, increment hec_err_cnt and set a sticky error flag. Then go to SEND.
- SEND: present bytes 0..52 in order. The byte advances only when out_valid&&out_ready. out_sop accompanies byte 0; out_eop and out_err accompany byte 52. After byte 52 is accepted, go to HUNT.
- Rx_en is held at 1 throughout SEND.
- Counters saturate at 8'hFF.

## Timing
- Rx_en reacts to Rx_clav with one cycle of latency because it is registered.
- Back-to-back octets: with Rx_clav held at 1, Rx_en stays 0 and one octet is sampled per cycle.
- Rx_clav=0 mid-cell pauses requests. The partial cell is held indefinitely.
- The cycle in which byte 52 is requested drives the next-state Rx_en to 1. Exactly 53 octets are sampled per cell.
- out_valid rises in the cycle after byte 52 is sampled.
- out_data, out_sop, out_eop and out_err are registered. They are held stable while out_valid=1 and out_ready=0.
- Sustained throughput with out_ready=1: one byte per cycle. Bytes 1..52 follow byte 0 without bubbles.
- Reset asserted mid-cell or mid-SEND immediately drops the cell and applies the reset values. Counters clear.

## Test plan
- Idle cell 00 00 00 01 52 + 48×6A, clav=1, ready=1 -> Rx_en low for 53 cycles, out_valid asserted 53 cycles with sop on 00 and eop on the last 6A, out_err=0, hec_err_cnt=0.
- Header 00 00 00 00 with HEC byte 55 accepted; the same cell with HEC 54 and DROP_BAD_HEC=1 -> no out_valid, hec_err_cnt=1; with DROP_BAD_HEC=0 -> 53 bytes forwarded, out_err=1 on eop only.
- Three garbage octets with soc=0, then a good cell -> the garbage is discarded and the cell is delivered intact.
- Rx_soc reasserted at byte 20, followed by a full cell -> runt_cnt=1 and only the second cell is delivered.
- Rx_clav toggling 1/0 every 4 cycles and out_ready random at 50% -> exactly 53 samples, data stable under backpressure, Rx_en=1 throughout SEND.
- rst=0 pulse at byte 30 of RECV and at byte 10 of SEND -> all outputs return to their reset values immediately; the next good cell is delivered correctly.
